// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The master issues start/a/b/cin; the slave returns busy/done/sum/carry.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (output start, a, b, cin, input  busy, done, sum, carry);
  modport slave  (input  start, a, b, cin, output busy, done, sum, carry);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, fixed WIDTH-cycle latency.
// The full add for each bit is two half-adder stages plus an OR of their carries.
module serial_adder_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, nstate;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rb;
  logic             c;
  logic             p, g1, s, g2, cout, last;

  serial_adder_ha u_ha0 (.x(acc[0]), .y(rb[0]), .s(p), .c(g1));
  serial_adder_ha u_ha1 (.x(p),      .y(c),     .s(s), .c(g2));
  assign cout = g1 | g2;
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (bus.start) nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // acc holds operand A and doubles as the result register: each sum bit
  // enters at the MSB as the consumed A bit leaves at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      rb        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      bus.sum   <= '0;
      bus.carry <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          acc <= bus.a;
          rb  <= bus.b;
          c   <= bus.cin;
          cnt <= '0;
        end
        RUN: begin
          acc <= {s, acc[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          c   <= cout;
          cnt <= cnt + CW'(1);
          if (last) begin
            bus.sum   <= {s, acc[WIDTH-1:1]};
            bus.carry <= cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results computed
// with plain integer addition; a negedge monitor pops and compares on each done.
module tb_serial_adder;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    int           cyc;
  } exp_t;

  logic clk, rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares results, latency, busy length, one-cycle done, sum hold.
  int           busy_cnt = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] last_sum = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        chk("done_single_cycle", 32'(prev_done), 0);
        chk("busy_low_in_done", 32'(bus.busy), 0);
        if (q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("sum", 32'(bus.sum), 32'(e.sum));
          chk("carry", 32'(bus.carry), 32'(e.carry));
          chk("latency_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, W);
        end
        busy_cnt = 0;
      end else begin
        chk("sum_hold", 32'(bus.sum), 32'(last_sum));
      end
      prev_done = bus.done;
    end
    last_sum = bus.sum;
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input int done_cyc);
    exp_t e;
    int   t;
    t       = int'(a) + int'(b) + int'(ci);
    e.sum   = W'(t % (1 << W));
    e.carry = (t >= (1 << W));
    e.cyc   = done_cyc;
    return e;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input bit disturb);
    bit seen;
    bus.a = ia; bus.b = ib; bus.cin = ic; bus.start = 1'b1;
    @(posedge clk); #1;
    q.push_back(model(ia, ib, ic, cyc + W));
    bus.start = 1'b0;
    if (disturb) begin
      bus.a = '1; bus.b = '1; bus.cin = 1'b1;
      @(posedge clk); #1; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 3 * W && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #2;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_carry", 32'(bus.carry), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed corners, then start changes mid-run.
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    chk("idle_busy", 32'(bus.busy), 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op(8'h03, 8'h04, 1'b0, 1'b1);
    repeat (2 * W) @(posedge clk);
    #1 chk("no_extra_done_queue", q.size(), 0);

    for (int n = 0; n < 24; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    // Abort 4 cycles into RUN.
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_sum", 32'(bus.sum), 0);
    chk("abort_carry", 32'(bus.carry), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2 * W) @(posedge clk);
    #1;
    chk("abort_sum_after", 32'(bus.sum), 0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);

    // Start held high: back-to-back operations every W+2 cycles.
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 k = cyc;
    for (int j = 0; j < 3; j++) q.push_back(model(8'h01, 8'h01, 1'b0, k + W + j * (W + 2)));
    while (cyc < k + 2 * (W + 2) + W + 1) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (2 * W) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit count; the block supports WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a, b and cin; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on the accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on the accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on the accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an addition is in progress (RUN state).
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that sum and carry hold a new result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result (a + b + cin) mod 2^WIDTH.
REQ-011 The block SHALL have port carry, output, 1 bit: registered carry-out of the addition.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and cin, clear the bit counter to 0, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-015 In RUN, each edge SHALL process one bit, LSB first, as a full add built from two half-adder stages: s = a[i]^b[i]^c and c' = a[i]&b[i] | c&(a[i]^b[i]).
REQ-016 The running carry c SHALL start at the captured cin, and each s SHALL shift into an internal result register.
REQ-017 The bit counter SHALL increment once per RUN edge and be wide enough to count 0..WIDTH-1 with no wrap before the last bit.
REQ-018 On the RUN edge that processes bit WIDTH-1, the block SHALL load sum with the full result and carry with the final c', and enter DONE.
REQ-019 Latency SHALL be fixed: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH, independent of operand values.
REQ-020 busy SHALL be 1 exactly while in RUN (WIDTH cycles per operation) and 0 in IDLE and DONE.
REQ-021 done SHALL be 1 exactly while in DONE, for one cycle, and DONE SHALL return to IDLE unconditionally on the next edge.
REQ-022 start SHALL be ignored in RUN and DONE; a, b and cin changes during RUN SHALL NOT affect the result.
REQ-023 If start is held high continuously, the next operation SHALL be accepted on the first IDLE edge after DONE, giving a WIDTH+2 cycle repeat period.
REQ-024 sum and carry SHALL change only on entry to DONE and SHALL hold their values through IDLE until the next result completes.

Reset
REQ-025 When rst_n=0, state SHALL go to IDLE immediately, and busy, done, sum, carry, the counter and internal registers SHALL be 0, without waiting for a clock edge.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no partial result on sum.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-028 The bench (WIDTH=8) SHALL check a=0x00, b=0x00, cin=0 -> sum=0x00, carry=0, done exactly 8 cycles after the start edge, busy high for 8 cycles.
REQ-029 The bench SHALL check a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1; and a=0x7F, b=0x01, cin=0 -> sum=0x80, carry=0.
REQ-030 The bench SHALL check a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry=1.
REQ-031 The bench SHALL check that with a=0x03, b=0x04 started and the inputs then changed to 0xFF/0xFF with start pulsed during RUN -> sum=0x07, carry=0, and only one done pulse.
REQ-032 The bench SHALL check that rst_n driven low 4 cycles into RUN for 0xFF+0xFF -> busy=0, done never pulses, sum=0x00; a following 0x10+0x20 -> sum=0x30.
REQ-033 The bench SHALL check that start held high with fixed operands 0x01+0x01 -> done pulses every 10 cycles, and sum=0x02 is stable between pulses.
